// File: rtl/multdiv_pkg.sv
// Shared constants and types for the multiply/divide sequencers.
package multdiv_pkg;

    localparam int unsigned OPERAND_WIDTH = 32;
    localparam int unsigned ACC_WIDTH     = 64;
    localparam int unsigned NUM_STEPS     = 16;
    localparam int unsigned STEP_WIDTH    = $clog2(NUM_STEPS);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } mult_state_e;

endpackage

// File: rtl/booth_step.sv
// Radix-4 Booth digit recoding and partial-product generation for one step.
module booth_step
    import multdiv_pkg::*;
(
    input  logic [OPERAND_WIDTH-1:0] a_i,
    input  logic [2:0]               window_i,
    input  logic [STEP_WIDTH-1:0]    step_i,
    output logic [ACC_WIDTH-1:0]     pp_o
);

    logic                 zero;
    logic                 dbl;
    logic                 neg;
    logic [ACC_WIDTH-1:0] a_ext;
    logic [ACC_WIDTH-1:0] mag;
    logic [ACC_WIDTH-1:0] signed_pp;

    // Recode the window {B[2i+1], B[2i], B[2i-1]} into a digit in {-2..+2}
    always_comb begin
        zero = 1'b0;
        dbl  = 1'b0;
        neg  = 1'b0;
        unique case (window_i)
            3'b000, 3'b111: zero = 1'b1;
            3'b001, 3'b010: ;
            3'b011:         dbl = 1'b1;
            3'b100:         begin dbl = 1'b1; neg = 1'b1; end
            3'b101, 3'b110: neg = 1'b1;
        endcase
    end

    // Build digit*A sign-extended to the accumulator width, then weight by 4^i
    always_comb begin
        a_ext = {{(ACC_WIDTH - OPERAND_WIDTH){a_i[OPERAND_WIDTH-1]}}, a_i};
        if (zero) begin
            mag = '0;
        end else if (dbl) begin
            mag = a_ext << 1;
        end else begin
            mag = a_ext;
        end
        signed_pp = neg ? (~mag + ACC_WIDTH'(1)) : mag;
        pp_o      = signed_pp << {step_i, 1'b0};
    end

endmodule

// File: rtl/mult_sequencer.sv
// Sequential signed 32x32 multiplier, one radix-4 Booth digit per clock.
module mult_sequencer
    import multdiv_pkg::*;
(
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     ctrl_MULT,
    input  logic [OPERAND_WIDTH-1:0] data_operandA,
    input  logic [OPERAND_WIDTH-1:0] data_operandB,
    output logic [OPERAND_WIDTH-1:0] data_result,
    output logic                     data_exception,
    output logic                     data_inputRDY,
    output logic                     data_resultRDY
);

    mult_state_e              state_q, state_d;
    logic [OPERAND_WIDTH-1:0] a_q, a_d;
    logic [OPERAND_WIDTH-1:0] b_q, b_d;
    logic [STEP_WIDTH-1:0]    step_q, step_d;
    logic [ACC_WIDTH-1:0]     acc_q, acc_d;
    logic [OPERAND_WIDTH-1:0] result_q, result_d;
    logic                     exception_q, exception_d;
    logic                     result_rdy_q, result_rdy_d;

    logic                     start;
    logic                     last_step;
    logic [OPERAND_WIDTH:0]   b_ext;
    logic [2:0]               window;
    logic [ACC_WIDTH-1:0]     pp;
    logic [ACC_WIDTH-1:0]     acc_sum;

    assign start     = ctrl_MULT & data_inputRDY;
    assign last_step = (state_q == StRun) && (step_q == STEP_WIDTH'(NUM_STEPS - 1));
    // Appending B[-1]=0 lets every window be a plain 3-bit slice
    assign b_ext     = {b_q, 1'b0};
    assign window    = b_ext[{step_q, 1'b0} +: 3];
    assign acc_sum   = acc_q + pp;

    booth_step u_booth_step (
        .a_i      (a_q),
        .window_i (window),
        .step_i   (step_q),
        .pp_o     (pp)
    );

    // FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; DONE may chain straight into RUN
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (last_step) state_d = StDone;
            StDone:  state_d = start ? StRun : StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs and registered result drive
    always_comb begin
        data_inputRDY  = (state_q != StRun);
        data_result    = result_q;
        data_exception = exception_q;
        data_resultRDY = result_rdy_q;
    end

    // Datapath next-state: operand capture, accumulation and result capture
    always_comb begin
        a_d          = a_q;
        b_d          = b_q;
        step_d       = step_q;
        acc_d        = acc_q;
        result_d     = result_q;
        exception_d  = exception_q;
        result_rdy_d = 1'b0;
        if (start) begin
            a_d    = data_operandA;
            b_d    = data_operandB;
            acc_d  = '0;
            step_d = '0;
        end else if (state_q == StRun) begin
            acc_d  = acc_sum;
            step_d = step_q + STEP_WIDTH'(1);
            if (last_step) begin
                result_d     = acc_sum[OPERAND_WIDTH-1:0];
                // Overflow when the upper half is not a pure sign extension
                exception_d  = acc_sum[ACC_WIDTH-1:OPERAND_WIDTH]
                               != {OPERAND_WIDTH{acc_sum[OPERAND_WIDTH-1]}};
                result_rdy_d = 1'b1;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_q          <= '0;
            b_q          <= '0;
            step_q       <= '0;
            acc_q        <= '0;
            result_q     <= '0;
            exception_q  <= 1'b0;
            result_rdy_q <= 1'b0;
        end else begin
            a_q          <= a_d;
            b_q          <= b_d;
            step_q       <= step_d;
            acc_q        <= acc_d;
            result_q     <= result_d;
            exception_q  <= exception_d;
            result_rdy_q <= result_rdy_d;
        end
    end

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed and random checks for mult_sequencer.
module tb_mult_sequencer;

    logic        clock;
    logic        reset;
    logic        ctrl_MULT;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_inputRDY;
    logic        data_resultRDY;

    int n_checks;
    int n_fail;

    mult_sequencer dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_inputRDY  (data_inputRDY),
        .data_resultRDY (data_resultRDY)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Issue a start, then wait (bounded) for the result pulse; lat=-1 on timeout
    task automatic do_mult(input logic [31:0] a, input logic [31:0] b,
                           output int lat, output logic [31:0] res, output logic exc);
        ctrl_MULT     = 1'b1;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock); #1;
        ctrl_MULT     = 1'b0;
        data_operandA = 32'hDEAD_BEEF;
        data_operandB = 32'h1234_5678;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clock); #1;
            if (data_resultRDY) begin
                lat = n;
                break;
            end
        end
        res = data_result;
        exc = data_exception;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ctrl_MULT = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        #12;
        n_checks++; if (data_result !== 32'd0) begin n_fail++;
            $display("FAIL reset_result got=%h exp=%h", data_result, 32'd0); end
        n_checks++; if (data_exception !== 1'b0) begin n_fail++;
            $display("FAIL reset_exception got=%b exp=0", data_exception); end
        n_checks++; if (data_resultRDY !== 1'b0) begin n_fail++;
            $display("FAIL reset_resultRDY got=%b exp=0", data_resultRDY); end
        n_checks++; if (data_inputRDY !== 1'b1) begin n_fail++;
            $display("FAIL reset_inputRDY got=%b exp=1", data_inputRDY); end
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_basic();
        int lat; logic [31:0] res; logic exc;
        do_mult(32'd7, 32'd6, lat, res, exc);
        n_checks++; if (lat !== 16) begin n_fail++;
            $display("FAIL basic_latency got=%0d exp=16", lat); end
        n_checks++; if (res !== 32'd42) begin n_fail++;
            $display("FAIL basic_result got=%h exp=%h", res, 32'd42); end
        n_checks++; if (exc !== 1'b0) begin n_fail++;
            $display("FAIL basic_exception got=%b exp=0", exc); end
        @(posedge clock); #1;
        n_checks++; if (data_resultRDY !== 1'b0) begin n_fail++;
            $display("FAIL basic_pulse_width got=%b exp=0", data_resultRDY); end
    endtask

    task automatic test_negative();
        int lat; logic [31:0] res; logic exc;
        do_mult(32'hFFFF_FFFD, 32'd5, lat, res, exc);
        n_checks++; if (res !== 32'hFFFF_FFF1) begin n_fail++;
            $display("FAIL neg_result got=%h exp=%h", res, 32'hFFFF_FFF1); end
        n_checks++; if (exc !== 1'b0) begin n_fail++;
            $display("FAIL neg_exception got=%b exp=0", exc); end
    endtask

    task automatic test_overflow();
        int lat; logic [31:0] res; logic exc;
        do_mult(32'h8000_0000, 32'hFFFF_FFFF, lat, res, exc);
        n_checks++; if (res !== 32'h8000_0000) begin n_fail++;
            $display("FAIL ovf_min_result got=%h exp=%h", res, 32'h8000_0000); end
        n_checks++; if (exc !== 1'b1) begin n_fail++;
            $display("FAIL ovf_min_exception got=%b exp=1", exc); end
        do_mult(32'h0001_0000, 32'h0001_0000, lat, res, exc);
        n_checks++; if (res !== 32'd0) begin n_fail++;
            $display("FAIL ovf_big_result got=%h exp=%h", res, 32'd0); end
        n_checks++; if (exc !== 1'b1) begin n_fail++;
            $display("FAIL ovf_big_exception got=%b exp=1", exc); end
    endtask

    // Start ignored mid-run, then a start accepted in the DONE cycle
    task automatic test_back_to_back();
        int lat;
        ctrl_MULT     = 1'b1;
        data_operandA = 32'd100;
        data_operandB = 32'hFFFF_FFF9;   // -7
        @(posedge clock); #1;
        ctrl_MULT = 1'b0;
        n_checks++; if (data_inputRDY !== 1'b0) begin n_fail++;
            $display("FAIL b2b_busy got=%b exp=0", data_inputRDY); end
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            if (n == 5) begin
                ctrl_MULT     = 1'b1;
                data_operandA = 32'd3;
                data_operandB = 32'd3;
            end
            @(posedge clock); #1;
            ctrl_MULT = 1'b0;
            if (data_resultRDY) begin
                lat = n;
                break;
            end
        end
        n_checks++; if (lat !== 16) begin n_fail++;
            $display("FAIL b2b_first_latency got=%0d exp=16", lat); end
        n_checks++; if (data_result !== 32'hFFFF_FD44) begin n_fail++;
            $display("FAIL b2b_first_result got=%h exp=%h", data_result, 32'hFFFF_FD44); end
        n_checks++; if (data_inputRDY !== 1'b1) begin n_fail++;
            $display("FAIL b2b_done_ready got=%b exp=1", data_inputRDY); end
        // Start in the DONE cycle: -9 * 11 = -99
        ctrl_MULT     = 1'b1;
        data_operandA = 32'hFFFF_FFF7;
        data_operandB = 32'd11;
        @(posedge clock); #1;
        ctrl_MULT = 1'b0;
        n_checks++; if (data_resultRDY !== 1'b0) begin n_fail++;
            $display("FAIL b2b_pulse_width got=%b exp=0", data_resultRDY); end
        n_checks++; if (data_inputRDY !== 1'b0) begin n_fail++;
            $display("FAIL b2b_no_gap got=%b exp=0", data_inputRDY); end
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            if (n == 8) begin
                n_checks++; if (data_result !== 32'hFFFF_FD44) begin n_fail++;
                    $display("FAIL b2b_hold got=%h exp=%h", data_result, 32'hFFFF_FD44); end
            end
            @(posedge clock); #1;
            if (data_resultRDY) begin
                lat = n;
                break;
            end
        end
        n_checks++; if (lat !== 16) begin n_fail++;
            $display("FAIL b2b_second_latency got=%0d exp=16", lat); end
        n_checks++; if (data_result !== 32'hFFFF_FF9D) begin n_fail++;
            $display("FAIL b2b_second_result got=%h exp=%h", data_result, 32'hFFFF_FF9D); end
        @(posedge clock); #1;
    endtask

    task automatic test_reset_mid_run();
        int lat; int pulses; logic [31:0] res; logic exc;
        ctrl_MULT     = 1'b1;
        data_operandA = 32'd5;
        data_operandB = 32'd5;
        @(posedge clock); #1;
        ctrl_MULT = 1'b0;
        repeat (8) begin @(posedge clock); #1; end
        #2 reset = 1'b1;
        #1;
        n_checks++; if (data_result !== 32'd0) begin n_fail++;
            $display("FAIL rst_run_result got=%h exp=%h", data_result, 32'd0); end
        n_checks++; if (data_exception !== 1'b0) begin n_fail++;
            $display("FAIL rst_run_exception got=%b exp=0", data_exception); end
        n_checks++; if (data_inputRDY !== 1'b1) begin n_fail++;
            $display("FAIL rst_run_inputRDY got=%b exp=1", data_inputRDY); end
        @(posedge clock); #1;
        reset = 1'b0;
        pulses = 0;
        repeat (20) begin
            @(posedge clock); #1;
            if (data_resultRDY) pulses++;
        end
        n_checks++; if (pulses !== 0) begin n_fail++;
            $display("FAIL rst_run_no_pulse got=%0d exp=0", pulses); end
        do_mult(32'd2, 32'd3, lat, res, exc);
        n_checks++; if (lat !== 16) begin n_fail++;
            $display("FAIL rst_after_latency got=%0d exp=16", lat); end
        n_checks++; if (res !== 32'd6) begin n_fail++;
            $display("FAIL rst_after_result got=%h exp=%h", res, 32'd6); end
    endtask

    task automatic test_random();
        int lat; logic [31:0] res; logic exc;
        logic [31:0] a, b, exp_res;
        logic        exp_exc;
        int          sa, sb;
        longint      prod;
        for (int i = 0; i < 1000; i++) begin
            a  = $urandom;
            b  = $urandom;
            if (i % 4 == 1) a = {{16{a[15]}}, a[15:0]};
            if (i % 4 == 2) b = {{20{b[11]}}, b[11:0]};
            sa = a;
            sb = b;
            prod    = longint'(sa) * longint'(sb);
            exp_res = prod[31:0];
            exp_exc = (prod[63:32] != {32{prod[31]}});
            do_mult(a, b, lat, res, exc);
            n_checks++; if (lat !== 16 || res !== exp_res) begin n_fail++;
                $display("FAIL rand_result a=%h b=%h got=%h exp=%h lat=%0d",
                         a, b, res, exp_res, lat); end
            n_checks++; if (exc !== exp_exc) begin n_fail++;
                $display("FAIL rand_exception a=%h b=%h got=%b exp=%b", a, b, exc, exp_exc); end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_basic();
        test_negative();
        test_overflow();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_sequencer.md
MULT_SEQUENCER -- requirements
Module: mult_sequencer

Interface
REQ-001 SHALL use one clock and an asynchronous, active-high reset: clock (input, 1) and reset (input, 1), listed first.
REQ-002 SHALL provide ctrl_MULT  input  1  start request, sampled on the rising clock edge.
REQ-003 SHALL provide data_operandA  input  32  signed multiplicand.
REQ-004 SHALL provide data_operandB  input  32  signed multiplier.
REQ-005 SHALL provide data_result  output  32  low 32 bits of the signed product, registered.
REQ-006 SHALL provide data_exception  output  1  signed overflow flag for data_result, registered.
REQ-007 SHALL provide data_inputRDY  output  1  high when a start will be accepted.
REQ-008 SHALL provide data_resultRDY  output  1  one-cycle pulse marking a valid result.

Function
REQ-009 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-010 SHALL drive data_inputRDY high in IDLE and DONE, and low in RUN.
REQ-011 SHALL accept a start on any edge where ctrl_MULT=1 and data_inputRDY=1: latch A and B, clear the 64-bit accumulator, set step=0, and enter RUN.
REQ-012 SHALL ignore ctrl_MULT while in RUN, with no effect on the operation in progress.
REQ-013 SHALL, in RUN, process one radix-4 Booth digit per edge:
- digit i is formed from B[2i+1], B[2i], B[2i-1], with B[-1]=0;
- the digit value is one of {-2, -1, 0, +1, +2};
- the operation is acc <= acc + sext64(digit*A) << 2i.
REQ-014 SHALL form 2A by a left shift and -X by two's complement, with all partial products sign-extended to 64 bits.
REQ-015 SHALL complete exactly 16 steps (i=0..15); the edge that executes step 15 SHALL move the FSM to DONE.
REQ-016 SHALL, on entry to DONE, register the outputs as follows:
- data_result = acc[31:0];
- data_exception = 1 iff acc[63:32] is not all copies of acc[31];
- data_resultRDY = 1.
REQ-017 SHALL hold data_resultRDY high for exactly one cycle, then leave DONE for IDLE, or for RUN if a start is accepted in that same cycle (back-to-back operation).
REQ-018 SHALL hold data_result and data_exception stable from DONE until the next DONE entry.
REQ-019 SHALL have a latency of 16 cycles from the start-accepting edge to the edge that raises data_resultRDY; back-to-back throughput is one result per 17 cycles.
REQ-020 SHALL leave the in-flight operation unaffected by operand input changes after the start edge.

Reset
REQ-021 SHALL, on reset assertion and independent of clock, force:
- FSM to IDLE;
- step=0 and acc=0;
- data_result=0, data_exception=0, data_resultRDY=0, data_inputRDY=1.
REQ-022 SHALL, on reset during RUN, abort the operation with no data_resultRDY pulse; the first start after reset release SHALL behave normally.

Structure
REQ-023 SHALL place the FSM state encoding, OPERAND_WIDTH=32, ACC_WIDTH=64 and NUM_STEPS=16 in a shared multdiv package.
REQ-024 SHALL implement digit recoding and partial-product generation in one combinational sub-module, booth_step (inputs: A, 3-bit window, step index; output: 64-bit partial product).
REQ-025 SHALL keep the accumulator, step counter and FSM in mult_sequencer; the implementation SHALL fit in 120-400 lines of RTL.

Verification
REQ-026 SHALL cover: A=7, B=6 start -> data_resultRDY exactly 16 cycles later, data_result=42, data_exception=0.
REQ-027 SHALL cover: A=-3 (0xFFFFFFFD), B=5 -> data_result=0xFFFFFFF1, data_exception=0.
REQ-028 SHALL cover: A=0x80000000, B=-1 -> data_result=0x80000000, data_exception=1; and A=0x00010000, B=0x00010000 -> data_result=0, data_exception=1.
REQ-029 SHALL cover: ctrl_MULT pulsed at the 5th RUN cycle with new operands -> ignored, first result unchanged; then a start in the DONE cycle -> second result 16 cycles later, no gap cycle.
REQ-030 SHALL cover: reset asserted at RUN step 8 -> outputs zero immediately, data_inputRDY=1, no data_resultRDY pulse; next start with A=2, B=3 -> data_result=6.
REQ-031 SHALL cover: a random signed-operand sweep of at least 1000 vectors compared against a 64-bit reference product for both data_result and data_exception.
